// File: rtl/group_pack_pkg.sv
// group_pack_pkg: FSM encodings and lane-count width helper shared by group_pack.
package group_pack_pkg;
    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;
    function automatic int cnt_width(input int n);
        return $clog2(n);
    endfunction
endpackage

// File: rtl/group_pack_out.sv
// group_pack_out: downstream output register, holds word while the consumer stalls (GROUP_PACK_LAST_EN adds dn_last).
module group_pack_out
    import group_pack_pkg::*;
#(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_data,
`ifdef GROUP_PACK_LAST_EN
    input  logic         load_last,
    output logic         dn_last,
`endif
    input  logic         dn_ready,
    output logic [W-1:0] dn_data,
    output logic         dn_valid,
    output logic         dn_free
);
    assign dn_free = !dn_valid || dn_ready;
    always_ff @(posedge clk) begin
        if (rst) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
`ifdef GROUP_PACK_LAST_EN
            dn_last  <= 1'b0;
`endif
        end else if (load) begin
            dn_valid <= 1'b1;
            dn_data  <= load_data;
`ifdef GROUP_PACK_LAST_EN
            dn_last  <= load_last;
`endif
        end else if (dn_ready) begin
            dn_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/group_pack.sv
// group_pack: packs GROUP_NB serial numbers into one word (lane 0 first).
// GROUP_PACK_LAST_EN adds up_last/dn_last so a burst can close a zero-padded partial group.
module group_pack
    import group_pack_pkg::*;
#(
    parameter int GROUP_NB  = 4,
    parameter int NUM_WIDTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_WIDTH-1:0]          up_data,
    input  logic                          up_valid,
    output logic                          up_ready,
`ifdef GROUP_PACK_LAST_EN
    input  logic                          up_last,
    output logic                          dn_last,
`endif
    output logic [NUM_WIDTH*GROUP_NB-1:0] dn_data,
    output logic                          dn_valid,
    input  logic                          dn_ready
);
    localparam int CW = cnt_width(GROUP_NB);
    localparam int W  = NUM_WIDTH * GROUP_NB;

    if (GROUP_NB < 2) begin : g_bad_group_nb
        initial begin
            $display("group_pack: GROUP_NB must be >= 2");
            $finish;
        end
    end

    logic [0:0]    state;
    logic [CW-1:0] cnt;
    logic [W-1:0]  asm, merged, load_data;
    logic          accept, done, dn_free, load, last_in;
`ifdef GROUP_PACK_LAST_EN
    logic          asm_last, load_last;
    assign last_in   = up_last;
    assign load_last = (state == HOLD) ? asm_last : last_in;
`else
    assign last_in   = 1'b0;
`endif

    assign up_ready  = (state == FILL);
    assign accept    = up_valid && up_ready;
    assign done      = accept && (cnt == CW'(GROUP_NB - 1) || last_in);
    assign load      = dn_free && (done || state == HOLD);
    assign load_data = (state == HOLD) ? asm : merged;

    always_comb begin
        merged = asm;
        for (int i = 0; i < GROUP_NB; i++)
            merged[i*NUM_WIDTH +: NUM_WIDTH] = (CW'(i) == cnt) ? up_data : asm[i*NUM_WIDTH +: NUM_WIDTH];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= FILL;
            cnt   <= '0;
            asm   <= '0;
`ifdef GROUP_PACK_LAST_EN
            asm_last <= 1'b0;
`endif
        end else if (state == FILL) begin
            if (accept && !done) begin
                asm <= merged;
                cnt <= cnt + 1'b1;
            end else if (done && dn_free) begin
                asm <= '0;
                cnt <= '0;
            end else if (done) begin
                // output still busy: park the finished word in the assembly register
                asm   <= merged;
                cnt   <= '0;
                state <= HOLD;
`ifdef GROUP_PACK_LAST_EN
                asm_last <= last_in;
`endif
            end
        end else if (dn_free) begin
            asm   <= '0;
            cnt   <= '0;
            state <= FILL;
`ifdef GROUP_PACK_LAST_EN
            asm_last <= 1'b0;
`endif
        end
    end

    group_pack_out #(.W(W)) u_out (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (load_data),
`ifdef GROUP_PACK_LAST_EN
        .load_last (load_last),
        .dn_last   (dn_last),
`endif
        .dn_ready  (dn_ready),
        .dn_data   (dn_data),
        .dn_valid  (dn_valid),
        .dn_free   (dn_free)
    );
endmodule

// File: tb/tb_group_pack.sv
// tb_group_pack: directed and randomized checks of group_pack against a queue-based group model.
module tb_group_pack;
    localparam int G  = 4;
    localparam int NW = 16;
    localparam int W  = G * NW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NW-1:0] up_data = '0;
    logic          up_valid = 1'b0;
    logic          up_ready;
    logic [W-1:0]  dn_data;
    logic          dn_valid;
    logic          dn_ready = 1'b1;
    logic          up_last = 1'b0;
`ifdef GROUP_PACK_LAST_EN
    logic          dn_last;
`endif

    int checks = 0;
    int errors = 0;

    group_pack #(.GROUP_NB(G), .NUM_WIDTH(NW)) dut (
        .clk      (clk),
        .rst      (rst),
        .up_data  (up_data),
        .up_valid (up_valid),
        .up_ready (up_ready),
`ifdef GROUP_PACK_LAST_EN
        .up_last  (up_last),
        .dn_last  (dn_last),
`endif
        .dn_data  (dn_data),
        .dn_valid (dn_valid),
        .dn_ready (dn_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [NW-1:0] v, input logic l);
        check("up_ready_before_send", up_ready, 1'b1);
        up_valid = 1'b1;
        up_data  = v;
        up_last  = l;
        tick();
        up_valid = 1'b0;
        up_last  = 1'b0;
    endtask

    function automatic logic [W-1:0] pack4(input int a, input int b, input int c, input int d);
        logic [W-1:0] r;
        r = '0;
        r[0*NW +: NW] = NW'(a);
        r[1*NW +: NW] = NW'(b);
        r[2*NW +: NW] = NW'(c);
        r[3*NW +: NW] = NW'(d);
        return r;
    endfunction

    logic [W-1:0] exp_q[$];
    logic [W-1:0] acc_word, prev_data, held_a, held_b;
    int lane, sent, recv;
    logic prev_stall;

    initial begin
        @(negedge clk);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("reset_dn_valid", dn_valid, 1'b0);
        check("reset_dn_data", dn_data, '0);
        check("reset_up_ready", up_ready, 1'b1);
`ifdef GROUP_PACK_LAST_EN
        check("reset_dn_last", dn_last, 1'b0);
`endif

        dn_ready = 1'b1;
        for (int i = 1; i <= 4; i++) send(NW'(i), 1'b0);
        check("t1_valid", dn_valid, 1'b1);
        check("t1_data", dn_data, pack4(1, 2, 3, 4));
        tick();
        check("t1_valid_drop", dn_valid, 1'b0);

        for (int i = 0; i < 8; i++) begin
            send(NW'(16'h10 + i), 1'b0);
            if (i == 3) begin
                check("t2_w0_valid", dn_valid, 1'b1);
                check("t2_w0_data", dn_data, pack4(16'h10, 16'h11, 16'h12, 16'h13));
            end
            if (i == 7) begin
                check("t2_w1_valid", dn_valid, 1'b1);
                check("t2_w1_data", dn_data, pack4(16'h14, 16'h15, 16'h16, 16'h17));
            end
        end
        tick();

        held_a = pack4(16'h20, 16'h21, 16'h22, 16'h23);
        held_b = pack4(16'h24, 16'h25, 16'h26, 16'h27);
        dn_ready = 1'b0;
        for (int i = 0; i < 8; i++) send(NW'(16'h20 + i), 1'b0);
        check("t3_hold_up_ready", up_ready, 1'b0);
        check("t3_first_held", dn_data, held_a);
        tick();
        check("t3_still_held", dn_data, held_a);
        check("t3_still_valid", dn_valid, 1'b1);
        check("t3_still_blocked", up_ready, 1'b0);
        dn_ready = 1'b1;
        tick();
        dn_ready = 1'b0;
        check("t3_second_valid", dn_valid, 1'b1);
        check("t3_second_data", dn_data, held_b);
        check("t3_up_ready_back", up_ready, 1'b1);
        tick();
        check("t3_second_held", dn_data, held_b);
        dn_ready = 1'b1;
        tick();
        check("t3_drained", dn_valid, 1'b0);

        send(NW'(16'h31), 1'b0);
        send(NW'(16'h32), 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_reset_valid", dn_valid, 1'b0);
        for (int i = 5; i <= 8; i++) send(NW'(i), 1'b0);
        check("t5_valid", dn_valid, 1'b1);
        check("t5_data", dn_data, pack4(5, 6, 7, 8));
        tick();

`ifdef GROUP_PACK_LAST_EN
        send(NW'(16'hA), 1'b0);
        send(NW'(16'hB), 1'b1);
        check("last_short_data", dn_data, pack4(16'hA, 16'hB, 0, 0));
        check("last_short_flag", dn_last, 1'b1);
        for (int i = 1; i <= 4; i++) send(NW'(i), i == 4);
        check("last_full_data", dn_data, pack4(1, 2, 3, 4));
        check("last_full_flag", dn_last, 1'b1);
        for (int i = 5; i <= 8; i++) send(NW'(i), 1'b0);
        check("last_next_data", dn_data, pack4(5, 6, 7, 8));
        check("last_next_flag", dn_last, 1'b0);
        tick();
`endif

        acc_word   = '0;
        lane       = 0;
        sent       = 0;
        recv       = 0;
        prev_stall = 1'b0;
        prev_data  = '0;
        for (int cyc = 0; cyc < 60000 && recv < 2500; cyc++) begin
            if (prev_stall) begin
                check("stall_valid", dn_valid, 1'b1);
                check("stall_data", dn_data, prev_data);
            end
            up_valid = (sent < 10000) && ($urandom_range(0, 3) != 0);
            up_data  = NW'($urandom);
            dn_ready = $urandom_range(0, 2) != 0;
            if (dn_valid && dn_ready) begin
                if (exp_q.size() == 0) check("spurious_word", 1'b1, 1'b0);
                else check("rand_data", dn_data, exp_q.pop_front());
                recv++;
            end
            if (up_valid && up_ready) begin
                acc_word[lane*NW +: NW] = up_data;
                lane++;
                sent++;
                if (lane == G) begin
                    exp_q.push_back(acc_word);
                    acc_word = '0;
                    lane = 0;
                end
            end
            prev_stall = dn_valid && !dn_ready;
            prev_data  = dn_data;
            tick();
        end
        up_valid = 1'b0;
        check("rand_words_received", 64'(recv), 64'd2500);
        check("rand_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
